// File: rtl/tub_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tub_scan_ctrl_pkg
// Brief    : Shared constants and helpers for the seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package tub_scan_ctrl_pkg;

    localparam int SEG_W      = 8;
    localparam int DUTY_W     = 4;
    localparam int DUTY_STEPS = 16;

    // Logical (pre-polarity) pattern for a dark digit.
    localparam logic [SEG_W-1:0] SEG_BLANK = '0;

    // Width of a digit index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tub_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tub_scan_ctrl_if
// Brief    : Host-side load/brightness bus between the display register block
//            and the scan driver.
// Revision : 1.0 - initial release
// ============================================================================
interface tub_scan_ctrl_if
    import tub_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 8
);
    logic [NUM_DIGITS*SEG_W-1:0] seg_data;
    logic [NUM_DIGITS-1:0]       blank_mask;
    logic [NUM_DIGITS-1:0]       blink_mask;
    logic                        load;
    logic [DUTY_W-1:0]           duty;
    logic                        load_ack;
    logic                        frame_start;

    // Register block side.
    modport master (
        output seg_data, blank_mask, blink_mask, load, duty,
        input  load_ack, frame_start
    );

    // Scan driver side.
    modport slave (
        input  seg_data, blank_mask, blink_mask, load, duty,
        output load_ack, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/tub_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tub_prescaler
// Brief    : Enabled modulo-DIV counter; tick marks the enabled last count.
// Revision : 1.0 - initial release
// ============================================================================
module tub_prescaler #(
    parameter int DIV   = 16,
    parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    output logic [CNT_W-1:0]      count,
    output logic                  tick
);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;

    assign tick  = en && (r_count == c_last);
    assign count = r_count;

    // Count enabled cycles, returning to zero after the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en) begin
            if (tick) r_count <= '0;
            else      r_count <= r_count + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/tub_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tub_scan_ctrl
// Brief    : Time-multiplexed seven-segment scan driver with frame-synchronous
//            double-buffered loads, blank/blink masks and PWM brightness.
// Revision : 1.0 - initial release
// ============================================================================
module tub_scan_ctrl
    import tub_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_DIV  = 50,
    parameter int SEL_ACT_HI = 1,
    parameter int SEG_ACT_HI = 1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    tub_scan_ctrl_if.slave         bus,
    output logic [NUM_DIGITS-1:0]  tub_sel,
    output logic [SEG_W-1:0]       tub_left,
    output logic [SEG_W-1:0]       tub_right
);
    localparam int IDX_W     = idx_width(NUM_DIGITS);
    localparam int SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int SLOT_STEP = SCAN_DIV / DUTY_STEPS;

    localparam logic [IDX_W-1:0]      c_last_idx = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      c_half_idx = IDX_W'(NUM_DIGITS / 2);
    localparam logic [NUM_DIGITS-1:0] c_sel_inv  = {NUM_DIGITS{(SEL_ACT_HI == 0)}};
    localparam logic [SEG_W-1:0]      c_seg_inv  = {SEG_W{(SEG_ACT_HI == 0)}};

    // Scan position.
    logic [SLOT_W-1:0] w_slot_cnt;
    logic              w_slot_tick;
    logic [IDX_W-1:0]  r_idx;
    logic              w_boundary;

    // Blink timing.
    logic [FRM_W-1:0]  w_unused_frame_cnt;
    logic              w_frame_tick;
    logic              r_blink_phase;

    // Double-buffered display image.
    logic [NUM_DIGITS*SEG_W-1:0] r_stg_seg,   r_act_seg;
    logic [NUM_DIGITS-1:0]       r_stg_blank, r_act_blank;
    logic [NUM_DIGITS-1:0]       r_stg_blink, r_act_blink;
    logic                        r_pending;

    // Output stage.
    logic                  w_on;
    logic                  w_upper;
    logic [31:0]           w_thresh;
    logic [SEG_W-1:0]      w_seg;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] r_tub_sel;
    logic [SEG_W-1:0]      r_tub_left;
    logic [SEG_W-1:0]      r_tub_right;
    logic                  r_load_ack;
    logic                  r_frame_start;

    tub_prescaler #(
        .DIV   (SCAN_DIV),
        .CNT_W (SLOT_W)
    ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .count (w_slot_cnt),
        .tick  (w_slot_tick)
    );

    assign w_boundary = w_slot_tick && (r_idx == c_last_idx);

    tub_prescaler #(
        .DIV   (BLINK_DIV),
        .CNT_W (FRM_W)
    ) u_frame (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_boundary),
        .count (w_unused_frame_cnt),
        .tick  (w_frame_tick)
    );

    // Advance the digit index once per slot, wrapping after the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_slot_tick) begin
            r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Flip the blink phase every BLINK_DIV frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_phase <= 1'b0;
        end else if (w_frame_tick) begin
            r_blink_phase <= ~r_blink_phase;
        end
    end

    // Stage host loads and promote them only at a frame boundary, so a frame
    // never shows a mix of old and new data. A load coinciding with the
    // boundary lands in staging after the old staging has been promoted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_seg   <= '0;
            r_stg_blank <= '1;
            r_stg_blink <= '0;
            r_act_seg   <= '0;
            r_act_blank <= '1;
            r_act_blink <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_boundary && r_pending) begin
                r_act_seg   <= r_stg_seg;
                r_act_blank <= r_stg_blank;
                r_act_blink <= r_stg_blink;
                r_pending   <= 1'b0;
            end
            if (bus.load) begin
                r_stg_seg   <= bus.seg_data;
                r_stg_blank <= bus.blank_mask;
                r_stg_blink <= bus.blink_mask;
                r_pending   <= 1'b1;
            end
        end
    end

    // Decide whether the current digit is lit in this cycle of its slot.
    always_comb begin
        w_thresh = (32'(bus.duty) + 32'd1) * 32'(SLOT_STEP);
        w_on     = !r_act_blank[r_idx]
                && !(r_act_blink[r_idx] && r_blink_phase)
                && (32'(w_slot_cnt) < w_thresh);
        w_upper  = (r_idx >= c_half_idx);
        w_seg    = r_act_seg[r_idx*SEG_W +: SEG_W];
        w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
    end

    // Register the pin image; polarity is folded in only at this stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tub_sel     <= c_sel_inv;
            r_tub_left    <= c_seg_inv;
            r_tub_right   <= c_seg_inv;
            r_load_ack    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_tub_sel     <= (w_on ? w_onehot : '0) ^ c_sel_inv;
            r_tub_left    <= ((w_on && !w_upper) ? w_seg : SEG_BLANK) ^ c_seg_inv;
            r_tub_right   <= ((w_on &&  w_upper) ? w_seg : SEG_BLANK) ^ c_seg_inv;
            r_load_ack    <= w_boundary && r_pending;
            r_frame_start <= w_boundary;
        end
    end

    assign tub_sel         = r_tub_sel;
    assign tub_left        = r_tub_left;
    assign tub_right       = r_tub_right;
    assign bus.load_ack    = r_load_ack;
    assign bus.frame_start = r_frame_start;
endmodule
`default_nettype wire

// File: tb/tb_tub_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tub_scan_ctrl
// Brief    : Scoreboard bench for tub_scan_ctrl (4 digits, 16-cycle slots,
//            2-frame blink half-period) with directed and random loads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tub_scan_ctrl;
    localparam int N  = 4;
    localparam int S  = 16;
    localparam int B  = 2;
    localparam int FR = S * N;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] tub_sel;
    logic [7:0]   tub_left;
    logic [7:0]   tub_right;

    tub_scan_ctrl_if #(.NUM_DIGITS(N)) bus_if ();

    tub_scan_ctrl #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (S),
        .BLINK_DIV  (B),
        .SEL_ACT_HI (1),
        .SEG_ACT_HI (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .tub_sel   (tub_sel),
        .tub_left  (tub_left),
        .tub_right (tub_right)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] sel;
        logic [7:0]   left;
        logic [7:0]   right;
        logic         ack;
        logic         fs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: time since reset determines slot, digit and frame.
    longint       m_n;
    bit           m_pend;
    logic [7:0]   s_seg[N];
    logic [7:0]   a_seg[N];
    logic [N-1:0] s_blank, a_blank, s_blink, a_blink;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n     = 0;
            m_pend  = 0;
            s_blank = '1;
            a_blank = '1;
            s_blink = '0;
            a_blink = '0;
            for (int i = 0; i < N; i++) begin
                s_seg[i] = 8'h00;
                a_seg[i] = 8'h00;
            end
            q.delete();
        end else begin
            int   p, d, frame;
            bit   phase, bnd, lit;
            exp_t e;
            p     = int'(m_n % S);
            d     = int'((m_n / S) % N);
            frame = int'(m_n / FR);
            phase = ((frame / B) % 2) == 1;
            bnd   = (m_n % FR) == FR - 1;
            lit   = !a_blank[d] && !(a_blink[d] && phase)
                 && (p < (int'(bus_if.duty) + 1) * (S / 16));
            e.sel   = lit ? N'(1 << d) : '0;
            e.left  = (lit && d <  N/2) ? a_seg[d] : 8'h00;
            e.right = (lit && d >= N/2) ? a_seg[d] : 8'h00;
            e.ack   = bnd && m_pend;
            e.fs    = bnd;
            q.push_back(e);
            if (bnd && m_pend) begin
                a_seg   = s_seg;
                a_blank = s_blank;
                a_blink = s_blink;
                m_pend  = 0;
            end
            if (bus_if.load) begin
                for (int i = 0; i < N; i++) s_seg[i] = bus_if.seg_data[8*i +: 8];
                s_blank = bus_if.blank_mask;
                s_blink = bus_if.blink_mask;
                m_pend  = 1;
            end
            m_n = m_n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs must be dark during reset, else match the model.
    always begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            #1;
            check("reset_sel",   32'(tub_sel),            32'h0);
            check("reset_left",  32'(tub_left),           32'h0);
            check("reset_right", 32'(tub_right),          32'h0);
            check("reset_ack",   32'(bus_if.load_ack),    32'h0);
            check("reset_fs",    32'(bus_if.frame_start), 32'h0);
        end else if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("tub_sel",     32'(tub_sel),            32'(e.sel));
            check("tub_left",    32'(tub_left),           32'(e.left));
            check("tub_right",   32'(tub_right),          32'(e.right));
            check("load_ack",    32'(bus_if.load_ack),    32'(e.ack));
            check("frame_start", 32'(bus_if.frame_start), 32'(e.fs));
        end
    end

    task automatic do_load(input logic [31:0] seg, input logic [N-1:0] bl, input logic [N-1:0] bk);
        bus_if.seg_data   = seg;
        bus_if.blank_mask = bl;
        bus_if.blink_mask = bk;
        bus_if.load       = 1'b1;
        @(negedge clk);
        bus_if.load       = 1'b0;
    endtask

    task automatic wait_phase(input int k);
        for (int i = 0; i < 2 * FR && int'(m_n % FR) != k; i++) @(negedge clk);
    endtask

    initial begin
        bus_if.seg_data   = '0;
        bus_if.blank_mask = '0;
        bus_if.blink_mask = '0;
        bus_if.load       = 1'b0;
        bus_if.duty       = 4'd15;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: dark, frame_start only.
        repeat (200) @(negedge clk);

        // Full brightness image.
        do_load(32'h3F065B4F, 4'b0000, 4'b0000);
        repeat (150) @(negedge clk);

        // Dimmed slots, including changes mid-slot.
        bus_if.duty = 4'd3;
        repeat (133) @(negedge clk);
        bus_if.duty = 4'd0;
        repeat (70) @(negedge clk);
        bus_if.duty = 4'd15;

        // Blink digit 1.
        do_load(32'h3F065B4F, 4'b0000, 4'b0010);
        repeat (5 * FR) @(negedge clk);

        // Two loads in one frame, then a load on the boundary cycle.
        wait_phase(10);
        do_load(32'h11223344, 4'b0000, 4'b0000);
        repeat (5) @(negedge clk);
        do_load(32'h55667788, 4'b0001, 4'b0000);
        wait_phase(FR - 1);
        do_load(32'h99AABBCC, 4'b0000, 4'b0000);
        repeat (2 * FR) @(negedge clk);

        // Random loads, masks and brightness.
        for (int it = 0; it < 40; it++) begin
            bus_if.duty = 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 90)) @(negedge clk);
            do_load($urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) do_load($urandom, 4'($urandom_range(0, 15)), 4'b0000);
        end

        // Reset mid-slot with a load pending.
        bus_if.duty = 4'd15;
        do_load(32'h3F065B4F, 4'b0000, 4'b0000);
        repeat (2 * FR) @(negedge clk);
        wait_phase(20);
        do_load(32'hFFFFFFFF, 4'b0000, 4'b0000);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * FR) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
